// File: rtl/ahb3lite_sram_initiator.sv
// ahb3lite_sram_initiator: AHB3-Lite slave bridging to a single-port synchronous SRAM.
module ahb3lite_sram_initiator #(
  parameter int MEM_SIZE_BYTE = 'h10000,
  parameter int PLEN = 32,
  parameter int XLEN = 32,
  parameter int WORD_AW = PLEN - 2
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [PLEN-1:0]    HADDR,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [1:0]         HTRANS,
  input  logic [XLEN-1:0]    HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [XLEN-1:0]    HRDATA,
  output logic               ce,
  output logic               we,
  output logic               oe,
  output logic [WORD_AW-1:0] waddr,
  output logic [XLEN-1:0]    din,
  output logic [3:0]         sel,
  input  logic [XLEN-1:0]    dout
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ACC, RD_DATA, ERR1, ERR2} state_t;
  localparam logic [PLEN:0] MEM_LIM = (PLEN+1)'(MEM_SIZE_BYTE);
  state_t state, state_nxt;
  logic [WORD_AW-1:0] addr_q;
  logic [3:0] sel_q, lanes;
  logic open, accept, err;
  always_comb begin
    open = state inside {IDLE, WRITE, RD_DATA, ERR2};
    accept = open && HSEL && HREADY && (HTRANS inside {2'b10, 2'b11});
    lanes = HSIZE == 3'b000 ? 4'b0001 << HADDR[1:0] :
            HSIZE == 3'b001 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    err = (HSIZE > 3'b010) || (HSIZE == 3'b001 && HADDR[0]) ||
          (HSIZE == 3'b010 && HADDR[1:0] != 2'b00) || ({1'b0, HADDR} >= MEM_LIM);
    state_nxt = accept ? (err ? ERR1 : HWRITE ? WRITE : RD_ACC) :
                state == RD_ACC ? RD_DATA : state == ERR1 ? ERR2 : IDLE;
  end
  // Error beats leave the SRAM address untouched so waddr keeps its last real value.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      addr_q <= '0;
      sel_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !err) begin
        addr_q <= HADDR[WORD_AW+1:2];
        sel_q <= lanes;
      end
    end
  end
  assign ce = state inside {WRITE, RD_ACC};
  assign we = state == WRITE;
  assign oe = state == RD_ACC;
  assign waddr = addr_q;
  assign din = state == WRITE ? HWDATA : '0;
  assign sel = state == WRITE ? sel_q : state == RD_ACC ? 4'b1111 : 4'b0000;
  assign HREADYOUT = !(state inside {RD_ACC, ERR1});
  assign HRESP = state inside {ERR1, ERR2};
  assign HRDATA = state == RD_DATA ? dout : '0;
endmodule

// File: tb/tb_ahb3lite_sram_initiator.sv
// tb_ahb3lite_sram_initiator: directed checks of the AHB3-Lite SRAM bridge against a behavioural SRAM.
module tb_ahb3lite_sram_initiator;
  logic HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, ce, we, oe;
  logic [31:0] HADDR, HWDATA, HRDATA, din, dout;
  logic [29:0] waddr;
  logic [2:0] HSIZE;
  logic [1:0] HTRANS;
  logic [3:0] sel;
  logic [31:0] mem [256];
  logic [31:0] wd [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D, 32'h5A5A_A5A5};
  int passes = 0, total = 0;
  localparam logic [1:0] NONSEQ = 2'b10, SEQ = 2'b11, BUSY = 2'b01;

  ahb3lite_sram_initiator dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .ce(ce), .we(we), .oe(oe),
    .waddr(waddr), .din(din), .sel(sel), .dout(dout)
  );

  assign HREADY = HREADYOUT;
  initial HCLK = 0;
  always #5 HCLK = ~HCLK;

  // Behavioural SRAM: byte-masked write, read data valid the cycle after the access.
  always @(posedge HCLK) begin
    if (ce && we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) mem[waddr[7:0]][b*8 +: 8] <= din[b*8 +: 8];
    if (ce && !we) dout <= mem[waddr[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic ph(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr);
    HSEL = 1; HWRITE = w; HADDR = a; HSIZE = sz; HTRANS = tr;
  endtask

  task automatic nop;
    HSEL = 0; HWRITE = 0; HTRANS = 2'b00;
  endtask

  task automatic tick;
    @(posedge HCLK); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    dout = '0; HRESETn = 0; HWDATA = '0; HADDR = '0; HSIZE = 3'b010; nop;
    #12;
    chk("rst_hreadyout", 32'(HREADYOUT), 1); chk("rst_hresp", 32'(HRESP), 0);
    chk("rst_hrdata", HRDATA, 0); chk("rst_ce", 32'(ce), 0); chk("rst_we", 32'(we), 0);
    chk("rst_oe", 32'(oe), 0); chk("rst_waddr", 32'(waddr), 0); chk("rst_sel", 32'(sel), 0);
    @(negedge HCLK); HRESETn = 1;
    // word write then read back
    ph(1, 32'h10, 3'b010, NONSEQ);
    tick; HWDATA = 32'hDEADBEEF; ph(0, 32'h10, 3'b010, NONSEQ); #1;
    chk("wr_ce", 32'(ce), 1); chk("wr_we", 32'(we), 1); chk("wr_oe", 32'(oe), 0);
    chk("wr_waddr", 32'(waddr), 4); chk("wr_sel", 32'(sel), 4'hF);
    chk("wr_din", din, 32'hDEADBEEF); chk("wr_hready", 32'(HREADYOUT), 1);
    tick; nop; #1;
    chk("rda_ce", 32'(ce), 1); chk("rda_we", 32'(we), 0); chk("rda_oe", 32'(oe), 1);
    chk("rda_sel", 32'(sel), 4'hF); chk("rda_hready", 32'(HREADYOUT), 0);
    tick; #1;
    chk("rdd_data", HRDATA, 32'hDEADBEEF); chk("rdd_hresp", 32'(HRESP), 0);
    chk("rdd_hready", 32'(HREADYOUT), 1); chk("rdd_ce", 32'(ce), 0);
    tick; #1;
    chk("idle_hrdata", HRDATA, 0); chk("idle_waddr_hold", 32'(waddr), 4); chk("idle_sel", 32'(sel), 0);
    // byte then halfword writes, pipelined, then read back
    ph(1, 32'h13, 3'b000, NONSEQ);
    tick; HWDATA = 32'hAB00_0000; ph(1, 32'h12, 3'b001, NONSEQ); #1;
    chk("byte_sel", 32'(sel), 4'b1000);
    tick; HWDATA = 32'h1234_0000; ph(0, 32'h10, 3'b010, NONSEQ); #1;
    chk("half_sel", 32'(sel), 4'b1100); chk("half_waddr", 32'(waddr), 4);
    tick; nop; #1;
    chk("bh_rda_hready", 32'(HREADYOUT), 0);
    tick; #1;
    chk("bh_readback", HRDATA, 32'h1234_BEEF);
    // misaligned halfword then out-of-range word, back to back
    tick; ph(1, 32'h11, 3'b001, NONSEQ);
    tick; nop; #1;
    chk("mis_e1_hresp", 32'(HRESP), 1); chk("mis_e1_hready", 32'(HREADYOUT), 0); chk("mis_e1_ce", 32'(ce), 0);
    tick; #1;
    chk("mis_e2_hresp", 32'(HRESP), 1); chk("mis_e2_hready", 32'(HREADYOUT), 1); chk("mis_e2_ce", 32'(ce), 0);
    ph(0, 32'h0001_0000, 3'b010, NONSEQ);
    tick; nop; #1;
    chk("oor_e1_hresp", 32'(HRESP), 1); chk("oor_e1_hready", 32'(HREADYOUT), 0); chk("oor_e1_ce", 32'(ce), 0);
    tick; #1;
    chk("oor_e2_hresp", 32'(HRESP), 1); chk("oor_e2_hready", 32'(HREADYOUT), 1); chk("oor_e2_ce", 32'(ce), 0);
    tick; #1;
    chk("err_done_hresp", 32'(HRESP), 0); chk("err_waddr_hold", 32'(waddr), 4);
    // oversize transfer
    ph(0, 32'h10, 3'b011, NONSEQ);
    tick; nop; #1;
    chk("size_e1_hresp", 32'(HRESP), 1); chk("size_e1_oe", 32'(oe), 0);
    tick; tick;
    // 4-beat burst write, BUSY and IDLE beats, 4-beat burst read
    ph(1, 32'h20, 3'b010, NONSEQ);
    for (int i = 0; i < 4; i++) begin
      tick; HWDATA = wd[i];
      if (i < 3) ph(1, 32'h20 + 32'(4 * (i + 1)), 3'b010, SEQ);
      else ph(1, 32'h30, 3'b010, BUSY);
      #1;
      chk("bw_we", 32'(we), 1); chk("bw_waddr", 32'(waddr), 32'(8 + i)); chk("bw_hready", 32'(HREADYOUT), 1);
    end
    tick; ph(0, 32'h30, 3'b010, 2'b00); #1;
    chk("busy_hready", 32'(HREADYOUT), 1); chk("busy_hresp", 32'(HRESP), 0); chk("busy_ce", 32'(ce), 0);
    tick; ph(0, 32'h20, 3'b010, NONSEQ); #1;
    chk("idlebeat_hready", 32'(HREADYOUT), 1); chk("idlebeat_ce", 32'(ce), 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i < 3) ph(0, 32'h20 + 32'(4 * (i + 1)), 3'b010, SEQ);
      else nop;
      #1;
      chk("br_oe", 32'(oe), 1); chk("br_waddr", 32'(waddr), 32'(8 + i)); chk("br_hready", 32'(HREADYOUT), 0);
      tick; #1;
      chk("br_data", HRDATA, wd[i]); chk("br_hready_data", 32'(HREADYOUT), 1);
    end
    // reset during a read access
    tick; ph(0, 32'h20, 3'b010, NONSEQ);
    tick; nop; #1;
    chk("rrst_pre_oe", 32'(oe), 1);
    HRESETn = 0; #1;
    chk("rrst_hready", 32'(HREADYOUT), 1); chk("rrst_ce", 32'(ce), 0); chk("rrst_oe", 32'(oe), 0);
    chk("rrst_waddr", 32'(waddr), 0); chk("rrst_sel", 32'(sel), 0); chk("rrst_hrdata", HRDATA, 0);
    tick; HRESETn = 1; ph(0, 32'h24, 3'b010, NONSEQ);
    tick; nop; #1;
    chk("post_rst_oe", 32'(oe), 1); chk("post_rst_waddr", 32'(waddr), 9);
    tick; #1;
    chk("post_rst_data", HRDATA, wd[1]);
    // reset during a write data phase: the write must never reach the SRAM
    tick; ph(1, 32'h24, 3'b010, NONSEQ);
    tick; nop; HWDATA = 32'hFFFF_FFFF; #1;
    chk("wrst_pre_we", 32'(we), 1);
    HRESETn = 0; #1;
    chk("wrst_we", 32'(we), 0); chk("wrst_ce", 32'(ce), 0);
    tick; tick; HRESETn = 1; ph(0, 32'h24, 3'b010, NONSEQ);
    tick; nop;
    tick; #1;
    chk("wrst_mem_unchanged", HRDATA, wd[1]);
    tick;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/ahb3lite_sram_initiator.md
AHB3LITE_SRAM_INITIATOR -- requirements
Module: ahb3lite_sram_initiator

Interface
REQ-001 Parameters SHALL be: MEM_SIZE_BYTE, default 'h10000, memory size in bytes. PLEN, default 32, AHB address width. XLEN, default 32, data width (only 32 supported). WORD_AW, default PLEN-2, SRAM word address width.
REQ-002 Ports SHALL be:
  HCLK  in  1  clock. One clock domain; all logic on its rising edge.
  HRESETn  in  1  reset. Asynchronous assertion, active-low.
  HSEL  in  1  slave select.
  HADDR  in  PLEN  byte address.
  HWRITE  in  1  1 = write.
  HSIZE  in  3  transfer size.
  HTRANS  in  2  transfer type.
  HWDATA  in  XLEN  write data.
  HREADY  in  1  bus ready.
  HREADYOUT  out  1  slave ready.
  HRESP  out  1  1 = ERROR.
  HRDATA  out  XLEN  read data.
  ce  out  1  SRAM chip enable.
  we  out  1  SRAM write enable.
  oe  out  1  SRAM output enable.
  waddr  out  WORD_AW  SRAM word address.
  din  out  XLEN  SRAM write data.
  sel  out  4  SRAM byte selects.
  dout  in  XLEN  SRAM read data. Valid on the cycle after a read access (ce=1, we=0).
REQ-003 HBURST, HPROT and HMASTLOCK SHALL NOT be ports; burst behaviour comes only from per-beat HTRANS.

Function
REQ-004 An address phase SHALL be accepted when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ.
- On acceptance, register: HADDR[PLEN-1:2], HWRITE, byte lanes, error flag.
REQ-005 The FSM states SHALL be IDLE, WRITE, RD_ACC, RD_DATA, ERR1, ERR2.
REQ-006 Transfers with HSEL=0, IDLE or BUSY SHALL get a zero-wait OKAY response (HREADYOUT=1, HRESP=0) and cause no SRAM access.
REQ-007 Byte lanes SHALL be derived from HSIZE and HADDR[1:0]:
- 000 (byte): sel = 1<<HADDR[1:0].
- 001 (halfword): sel = 4'b0011<<(2*HADDR[1]); requires HADDR[0]=0.
- 010 (word): sel = 4'b1111; requires HADDR[1:0]=0.
REQ-008 The error flag SHALL be set when:
- HSIZE > 010, or
- the access is misaligned, or
- HADDR >= MEM_SIZE_BYTE.
REQ-009 An accepted transfer with the error flag set SHALL go to ERR1, then ERR2, with no SRAM access.
- ERR1: HRESP=1, HREADYOUT=0.
- ERR2: HRESP=1, HREADYOUT=1.
- After ERR2: IDLE, or a new accepted transfer.
REQ-010 WRITE (data phase) SHALL last one cycle and drive, combinationally:
- ce=1, we=1, oe=0;
- waddr = registered word address; din = HWDATA; sel = registered lanes;
- HREADYOUT=1, HRESP=0.
REQ-011 A read SHALL take exactly one wait state.
- RD_ACC: ce=1, we=0, oe=1, waddr, sel=4'b1111, HREADYOUT=0.
- RD_DATA: ce=0, HRDATA = dout, HREADYOUT=1.
REQ-012 In WRITE, RD_DATA and ERR2, a new address phase SHALL be accepted in the same cycle, giving back-to-back pipelining.
- Write followed by read to the same address: the read SHALL return the newly written data (write is issued before the read's RD_ACC).
REQ-013 Outside RD_DATA, HRDATA SHALL be 0.
REQ-014 Outside WRITE and RD_ACC, SRAM outputs SHALL be idle:
- ce=0, we=0, oe=0, sel=0;
- waddr holds its last value.
REQ-015 The word address SHALL be HADDR[WORD_AW+1:2] with no wrap. Addresses at or above MEM_SIZE_BYTE are rejected per REQ-008.

Reset
REQ-016 While HRESETn=0, the block SHALL be:
- state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0;
- ce=0, we=0, oe=0, waddr=0, sel=0;
- all registered phase information cleared.
REQ-017 Reset asserted mid-transfer (any state) SHALL abort it immediately; no SRAM write SHALL occur after HRESETn falls.
REQ-018 The first acceptable transfer SHALL be the first qualifying HCLK edge after HRESETn deasserts.

Verification
REQ-019 Word write then read:
- NONSEQ write HADDR=0x10, HSIZE=010, HWDATA=0xDEADBEEF -> one cycle ce=1, we=1, waddr=0x4, sel=1111.
- Following read to the same address -> one wait cycle, then HRDATA=0xDEADBEEF, HRESP=0.
REQ-020 Byte and halfword writes:
- Byte write HADDR=0x13 -> sel=1000.
- Halfword write HADDR=0x12 -> sel=1100.
- Word read back -> only the addressed lanes changed.
REQ-021 Errors:
- Halfword at HADDR=0x11 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 both cycles), ce stays 0.
- HADDR=MEM_SIZE_BYTE -> the same two-cycle ERROR.
REQ-022 Back-to-back traffic:
- 4-beat SEQ write, then 4-beat read -> writes complete at one per cycle.
- Each read takes 2 cycles; all data correct.
- IDLE/BUSY beats in between -> zero-wait OKAY.
REQ-023 Reset mid-transfer:
- HRESETn pulsed low during RD_ACC -> outputs take reset values immediately.
- After release, a new read completes normally.
- A write pending at reset is never issued (memory content unchanged).
